// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier core between two requesters.
// Optional watchdog abort enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic [2*WIDTH-1:0] result,
  output logic               err,
  output logic               busy,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  output logic               mult_init,
  output logic               mult_rst,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_pp,
  output logic [2:0]         dbg_state
);

  // Requester handshake: reqN is a level held until ackN; ackN is a one-cycle
  // pulse with result/err valid in the same cycle; operands sampled only at grant.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_KICK      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CAPTURE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               win;
  logic               to_hit;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  assign to_hit = (cnt_q == CW'(TIMEOUT));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    err_d    = err_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    win      = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          win     = (req0 && req1) ? ~last_q : req1;
          id_d    = win;
          opa_d   = win ? a1 : a0;
          opb_d   = win ? b1 : b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_KICK;
      S_KICK: begin
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (to_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          ack0_d   = ~id_q;
          ack1_d   = id_q;
          state_d  = S_CAPTURE;
        end else if (!mult_done) begin
          // A high done here is stale from the previous product; the core
          // only accepts init once it is back in START with done low.
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (mult_done) begin
          result_d = mult_pp;
          err_d    = 1'b0;
          ack0_d   = ~id_q;
          ack1_d   = id_q;
          state_d  = S_CAPTURE;
        end else if (to_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          ack0_d   = ~id_q;
          ack1_d   = id_q;
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign mult_init = (state_q == S_KICK);
  assign mult_a    = opa_q;
  assign mult_b    = opb_q;
  assign dbg_state = state_q;

`ifdef MULT_ARB_TIMEOUT_EN
  // An aborted operation resets the core during the ack cycle.
  assign mult_rst = rst | ((state_q == S_CAPTURE) & err_q);
`else
  assign mult_rst = rst;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural core model, transaction-level arbiter model
// checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mult_arbiter;
  localparam int W          = 16;
  localparam int TB_TIMEOUT = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           ack0, ack1, err, busy, mult_init, mult_rst;
  logic           mult_done = 1'b0;
  logic [2*W-1:0] result;
  logic [2*W-1:0] mult_pp = '0;
  logic [W-1:0]   mult_a, mult_b;
  logic [2:0]     dbg_state;

  int checks = 0;
  int errors = 0;

  mult_arbiter #(.WIDTH(W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .result(result), .err(err), .busy(busy),
    .mult_a(mult_a), .mult_b(mult_b),
    .mult_init(mult_init), .mult_rst(mult_rst),
    .mult_done(mult_done), .mult_pp(mult_pp),
    .dbg_state(dbg_state)
  );

  int ncyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Multiplier core model: START -> BUSY (random latency) -> END (done held until next init)
  typedef enum int {C_START, C_BUSY, C_END} core_t;
  core_t      core_st = C_START;
  logic [W-1:0] core_a = '0, core_b = '0;
  int         core_cnt = 0;
  bit         core_stall = 1'b0;

  always @(posedge clk) begin
    if (mult_rst) begin
      core_st   <= C_START;
      mult_done <= 1'b0;
    end else begin
      case (core_st)
        C_START: if (mult_init) begin
          core_a   <= mult_a;
          core_b   <= mult_b;
          core_cnt <= $urandom_range(1, 5);
          mult_pp  <= $urandom;
          core_st  <= C_BUSY;
        end
        C_BUSY: if (!core_stall) begin
          if (core_cnt <= 1) begin
            mult_done <= 1'b1;
            mult_pp   <= (2*W)'(core_a) * (2*W)'(core_b);
            core_st   <= C_END;
          end else begin
            core_cnt <= core_cnt - 1;
          end
        end
        C_END: if (mult_init) begin
          core_st   <= C_START;
          mult_done <= 1'b0;
        end
        default: core_st <= C_START;
      endcase
    end
  end

  // Scoreboard / arbiter model: one operation in flight at a time
  typedef struct packed {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;
  op_t exp_q[$];

  bit             m_busy = 1'b0, m_last = 1'b1, m_kicked = 1'b0, m_err = 1'b0;
  int             m_grant = 0, m_ack_cyc = -1;
  logic [2*W-1:0] m_result = '0;
  bit             prev_done = 1'b0, prev_core_busy = 1'b0;
  int             mrst_pulses = 0;

  always @(negedge clk) begin
    bit             exp_ack, exp_init, to_ack, core_busy_now, w;
    op_t            cur;
    ncyc++;
    cur = '0;
    if (exp_q.size() > 0) cur = exp_q[0];
    core_busy_now = (core_st == C_BUSY);
    if (m_busy && core_busy_now && !prev_core_busy) m_kicked = 1'b1;
    if (m_busy && mult_done && !prev_done) m_ack_cyc = ncyc + 1;
    to_ack = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    if (m_busy && ncyc == m_grant + 3 + TB_TIMEOUT && ncyc != m_ack_cyc) to_ack = 1'b1;
`endif
    exp_ack  = m_busy && (ncyc == m_ack_cyc || to_ack);
    exp_init = m_busy && (ncyc >= m_grant + 2) && !m_kicked && !exp_ack;
    if (exp_ack) begin
      m_result = to_ack ? '0 : (2*W)'(cur.a) * (2*W)'(cur.b);
      m_err    = to_ack;
    end
    if (mult_rst && !rst) mrst_pulses++;

    chk("busy", busy, m_busy);
    chk("mult_init", mult_init, exp_init);
    chk("ack0", ack0, exp_ack && cur.id == 1'b0);
    chk("ack1", ack1, exp_ack && cur.id == 1'b1);
    chk("result", result, m_result);
    chk("err", err, m_err);
    chk("mult_rst", mult_rst, rst | to_ack);
    if (m_busy && ncyc >= m_grant + 1) begin
      chk("mult_a", mult_a, cur.a);
      chk("mult_b", mult_b, cur.b);
    end

    if (exp_ack) begin
      m_last = cur.id;
      void'(exp_q.pop_front());
      m_busy    = 1'b0;
      m_ack_cyc = -1;
    end else if (!m_busy && !rst && (req0 || req1)) begin
      w = (req0 && req1) ? !m_last : req1;
      exp_q.push_back('{id: w, a: (w ? a1 : a0), b: (w ? b1 : b0)});
      m_busy   = 1'b1;
      m_grant  = ncyc;
      m_kicked = 1'b0;
    end
    if (rst) begin
      m_busy    = 1'b0;
      m_last    = 1'b1;
      m_ack_cyc = -1;
      m_result  = '0;
      m_err     = 1'b0;
      exp_q.delete();
    end
    prev_done      = mult_done;
    prev_core_busy = core_busy_now;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any_ack(output logic [2*W-1:0] res, output logic e, output logic gid);
    res = '0; e = 1'b0; gid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (ack0 || ack1) begin
        res = result; e = err; gid = ack1;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL ack_wait: no ack within 200 cycles (cycle %0d)", ncyc);
  endtask

  task automatic run_one(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] res, output logic e, output logic gid,
                         output int dly, output int len, output int lat);
    int t;
    if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
    dly = 0; len = 0; t = 0;
    @(negedge clk);
    while (!mult_init && dly < 50) begin dly++; t++; @(negedge clk); end
    while (mult_init && len < 50) begin len++; t++; @(negedge clk); end
    while (!(ack0 || ack1) && t < 250) begin t++; @(negedge clk); end
    lat = t;
    wait_any_ack(res, e, gid);
    tick();
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic rand_requester(input logic id, input int nops);
    bit hold = 1'b0;
    bit got;
    for (int k = 0; k < nops; k++) begin
      if (!hold) repeat ($urandom_range(0, 3)) tick();
      if (id) begin a1 = W'($urandom); b1 = W'($urandom); req1 = 1'b1; end
      else    begin a0 = W'($urandom); b0 = W'($urandom); req0 = 1'b1; end
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
        @(negedge clk);
        if (id ? ack1 : ack0) got = 1'b1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL rand_ack%0d: no ack within 400 cycles", id);
      end
      tick();
      hold = ($urandom_range(0, 2) == 0) && (k < nops - 1);
      if (!hold) begin
        if (id) req1 = 1'b0; else req0 = 1'b0;
      end
    end
  endtask

  initial begin
    logic [2*W-1:0] res;
    logic           e, gid;
    int             dly, len, lat;
    logic [3:0]     gids;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ack", {ack1, ack0}, 0);
    chk("reset_result", result, 0);
    chk("reset_err", err, 0);
    chk("reset_init", mult_init, 0);
    chk("reset_operands", {mult_a, mult_b}, 0);
    tick();

    // single request after reset, core in START
    run_one(1'b0, 16'd7, 16'd6, res, e, gid, dly, len, lat);
    chk("single_id", gid, 0);
    chk("single_result", res, 42);
    chk("single_err", e, 0);
    chk("single_init_delay", dly, 2);
    chk("single_kick_len", len, 1);

    // core parked in END with done still high
    tick();
    run_one(1'b0, 16'd11, 16'd13, res, e, gid, dly, len, lat);
    chk("parked_kick_len", len, 2);
    chk("parked_result", res, 143);

    // simultaneous requests after reset
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    a0 = 16'd3; b0 = 16'd5; a1 = 16'hFFFF; b1 = 16'hFFFF;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    wait_any_ack(res, e, gid);
    chk("tie_first_id", gid, 0);
    chk("tie_first_result", res, 15);
    tick(); req0 = 1'b0;
    @(negedge clk);
    wait_any_ack(res, e, gid);
    chk("tie_second_id", gid, 1);
    chk("tie_second_result", res, 32'hFFFE0001);
    tick(); req1 = 1'b0;

    // fairness with both requests held
    tick();
    a0 = 16'd1; b0 = 16'd2; a1 = 16'd3; b1 = 16'd4;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wait_any_ack(res, e, gid);
      gids[k] = gid;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("fair_order", gids, 4'b1010);

    // reset during WAIT_DONE
    tick();
    core_stall = 1'b1;
    a1 = 16'd4; b1 = 16'd4; req1 = 1'b1;
    repeat (6) tick();
    rst = 1'b1; req1 = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ack", {ack1, ack0}, 0);
    core_stall = 1'b0;
    tick();
    run_one(1'b1, 16'd2, 16'd9, res, e, gid, dly, len, lat);
    chk("after_rst_id", gid, 1);
    chk("after_rst_result", res, 18);

`ifdef MULT_ARB_TIMEOUT_EN
    tick();
    core_stall  = 1'b1;
    mrst_pulses = 0;
    run_one(1'b0, 16'd5, 16'd5, res, e, gid, dly, len, lat);
    core_stall = 1'b0;
    chk("to_err", e, 1);
    chk("to_result", res, 0);
    chk("to_latency", lat, 3 + TB_TIMEOUT);
    chk("to_mult_rst_pulses", mrst_pulses, 1);
`endif

    // randomized traffic from both requesters
    tick();
    fork
      rand_requester(1'b0, 30);
      rand_requester(1'b1, 30);
    join
    repeat (12) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
